k2_program_loader: RTL and testbench

- Writer side of the K2 instruction-fetch interface.
- Receives a program as a byte stream over a valid/ready handshake and stores it in a 16x8 program RAM.
- The processor fetches from that RAM via ProgramAddress/instruction_data, replacing a fixed program ROM.
- Holds the processor in reset while loading and releases it when the load completes.

---
 rtl/k2_loader_pkg.sv | 6 +
 rtl/k2_program_ram.sv | 21 ++
 rtl/k2_program_loader.sv | 91 +++++++++
 tb/tb_k2_program_loader.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/k2_loader_pkg.sv
// k2_loader_pkg: shared loader state encoding and program-format constants
package k2_loader_pkg;
   typedef enum logic [2:0] {HOLD, LEN, DATA, FILL, CHECK, RUN, ERR} state_t;
   localparam logic [7:0] LEN_HDR_MASK = 8'hF0;
   localparam int PROG_DEPTH = 16;
endpackage

// File: rtl/k2_program_ram.sv
// k2_program_ram: program store, one synchronous write port, asynchronous read, cleared by rst
module k2_program_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   // clear the whole store on reset, otherwise take one write per cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/k2_program_loader.sv
// k2_program_loader: loads a length-prefixed byte stream into program RAM, holding the CPU until done.
// Define K2_LOADER_CHECKSUM_EN to require a trailing checksum byte that makes the stream sum zero.
module k2_program_loader
   import k2_loader_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = PROG_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] ProgramAddress,
   output logic [DATA_W-1:0] instruction_data,
   output logic              cpu_rst_n,
   output logic              done,
   output logic              err
);
   localparam int PW = ADDR_W + 1;
   state_t state, nxt, after_len, after_data;
   logic [PW-1:0] wr_ptr, len;
   logic [DATA_W-1:0] wdata, rdata;
   logic xfer, we, sum_ok;
   assign in_ready = state inside {LEN, DATA, CHECK};
   assign xfer = in_valid && in_ready;
   assign after_len = (len == PW'(DEPTH)) ? RUN : FILL;
   assign instruction_data = (state == RUN) ? rdata : '0;
`ifdef K2_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   assign after_data = CHECK;
   assign sum_ok = 8'(sum + in_data) == 8'd0;
   // running byte sum over header and data, restarted by each load_start
   always_ff @(posedge clk or posedge rst)
      if (rst) sum <= '0;
      else if (load_start) sum <= '0;
      else if (xfer) sum <= sum + in_data;
`else
   assign after_data = after_len;
   assign sum_ok = 1'b0;
`endif
   // next state and RAM write selection; load_start overrides any transfer
   always_comb begin
      nxt = state;
      we = 1'b0;
      wdata = in_data;
      if (load_start) nxt = LEN;
      else case (state)
         LEN: if (xfer) nxt = |(in_data & LEN_HDR_MASK) ? ERR : DATA;
         DATA: if (xfer) begin
            we = 1'b1;
            if (wr_ptr + PW'(1) == len) nxt = after_data;
         end
         CHECK: if (xfer) nxt = sum_ok ? after_len : ERR;
         FILL: begin
            we = 1'b1;
            wdata = '0;
            if (wr_ptr[ADDR_W-1:0] == '1) nxt = RUN;
         end
         default: ;
      endcase
   end
   // state, write pointer, program length and registered status outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= HOLD;
         wr_ptr <= '0;
         len <= '0;
         cpu_rst_n <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= nxt;
         wr_ptr <= load_start ? '0 : wr_ptr + PW'(we);
         if (state == LEN && xfer && !load_start) len <= {1'b0, in_data[ADDR_W-1:0]} + PW'(1);
         cpu_rst_n <= nxt == RUN;
         done <= nxt == RUN && state != RUN;
         err <= nxt == ERR;
      end
   k2_program_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
      .clk(clk),
      .rst(rst),
      .we(we),
      .waddr(wr_ptr[ADDR_W-1:0]),
      .wdata(wdata),
      .raddr(ProgramAddress),
      .rdata(rdata)
   );
endmodule

// File: tb/tb_k2_program_loader.sv
// tb_k2_program_loader: randomized loads checked against a byte-array model of the program RAM
module tb_k2_program_loader;
   logic clk = 1'b0, rst = 1'b1, load_start = 1'b0, in_valid = 1'b0;
   logic in_ready, cpu_rst_n, done, err;
   logic [7:0] in_data = 8'h00, instruction_data;
   logic [3:0] ProgramAddress = 4'h0;
   logic [7:0] pd [16];
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   k2_program_loader dut (
      .clk(clk),
      .rst(rst),
      .load_start(load_start),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .ProgramAddress(ProgramAddress),
      .instruction_data(instruction_data),
      .cpu_rst_n(cpu_rst_n),
      .done(done),
      .err(err)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int mx);
      int t = 0;
      repeat ($urandom_range(mx, 0)) @(negedge clk);
      ProgramAddress = 4'($urandom);
      in_valid = 1'b1;
      in_data = b;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("in_ready", in_ready, 1);
      #1 chk("idata_held", instruction_data, 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'($urandom);
   endtask

   task automatic expect_ram(input int n);
      for (int a = 0; a < 16; a++) begin
         ProgramAddress = 4'(a);
         #1 chk($sformatf("ram[%0d]", a), instruction_data, a < n ? int'(pd[a]) : 0);
         @(negedge clk);
      end
   endtask

   task automatic run_load(input int n, input int mx, input bit start);
      int c = 0;
      logic [7:0] s;
      if (start) pulse_start();
      s = 8'(n - 1);
      send(s, mx);
      for (int i = 0; i < n; i++) begin
         send(pd[i], mx);
         s = s + pd[i];
      end
`ifdef K2_LOADER_CHECKSUM_EN
      send(8'(8'd0 - s), mx);
`endif
      while (!cpu_rst_n && c < 40) begin
         @(negedge clk);
         c++;
      end
      chk("fill_cycles", c, 16 - n);
      chk("done_pulse", done, 1);
      chk("err_clear", err, 0);
      @(negedge clk);
      chk("done_once", done, 0);
      chk("cpu_run", cpu_rst_n, 1);
      chk("ready_run", in_ready, 0);
      expect_ram(n);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      for (int a = 0; a < 16; a++) begin
         ProgramAddress = 4'(a);
         #1 chk("rst_ram", instruction_data, 0);
      end
      rst = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cpu", cpu_rst_n, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_err", err, 0);
      chk("rst_done", done, 0);
      in_valid = 1'b0;

      pd[0] = 8'hA1; pd[1] = 8'hA2; pd[2] = 8'hA3; pd[3] = 8'hA4;
      run_load(4, 0, 1'b1);

      for (int k = 0; k < 16; k++) pd[k] = 8'(k);
      run_load(16, 3, 1'b1);

      pulse_start();
      chk("rehold_cpu", cpu_rst_n, 0);
      chk("rehold_ready", in_ready, 1);
      #1 chk("rehold_idata", instruction_data, 0);
      send(8'h15, 0);
      chk("hdr_err", err, 1);
      chk("hdr_ready", in_ready, 0);
      chk("hdr_cpu", cpu_rst_n, 0);
      repeat (3) @(negedge clk);
      chk("err_sticky", err, 1);
      pd[0] = 8'h3C;
      run_load(1, 1, 1'b1);

      pulse_start();
      send(8'h03, 0);
      send(8'h11, 0);
      send(8'h22, 0);
      load_start = 1'b1;
      in_valid = 1'b1;
      in_data = 8'hF7;
      @(negedge clk);
      load_start = 1'b0;
      in_valid = 1'b0;
      chk("abort_cpu", cpu_rst_n, 0);
      chk("abort_err", err, 0);
      pd[0] = 8'h55; pd[1] = 8'h66;
      run_load(2, 0, 1'b0);

`ifdef K2_LOADER_CHECKSUM_EN
      pd[0] = 8'h10; pd[1] = 8'h20;
      run_load(2, 0, 1'b1);
      pulse_start();
      send(8'h01, 0);
      send(8'h10, 0);
      send(8'h20, 0);
      send(8'h00, 0);
      chk("cks_err", err, 1);
      chk("cks_cpu", cpu_rst_n, 0);
      #1 chk("cks_idata", instruction_data, 0);
`endif

      for (int it = 0; it < 10; it++) begin
         int n;
         n = $urandom_range(16, 1);
         if ($urandom_range(1, 0) == 1) begin
            pulse_start();
            send(8'($urandom_range(15, 0)), 1);
            send(8'($urandom), 1);
         end
         for (int k = 0; k < 16; k++) pd[k] = 8'($urandom);
         run_load(n, 2, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
